// File: rtl/mem_req_arbiter.sv
// Two-master arbiter for a shared sram-like port; in-order responses are routed back via a source-ID FIFO.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default: data wins over inst).
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                     state, state_nxt;
    logic                       grant_q, grant_nxt;  // 0 = inst, 1 = data
    logic [CW-1:0]              cnt;
    logic [PW-1:0]              wptr, rptr;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic                       win, sel, active, push, pop, head;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // On conflict, favour whichever master was not granted last.
    assign win = data_req && (!inst_req || !last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b0;
        else if (push)
            last_grant <= sel;
    end
`else
    assign win = data_req;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        sel       = grant_q;
        active    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt < CNT_MAX && (inst_req || data_req)) begin
                    active = 1'b1;
                    sel    = win;
                    if (!mem_addr_ok) begin
                        state_nxt = HOLD;
                        grant_nxt = win;
                    end
                end
            end
            HOLD: begin
                active = 1'b1;
                if (mem_addr_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs must drop the moment reset is asserted, not at the next edge.
        if (reset)
            active = 1'b0;
    end

    assign push = active && mem_addr_ok;
    assign pop  = !reset && mem_data_ok && (cnt != '0);
    assign head = id_fifo[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            cnt     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            id_fifo <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            if (push) begin
                id_fifo[wptr] <= sel;
                wptr          <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (!push && pop)
                cnt <= cnt - 1'b1;
        end
    end

    assign mem_req   = active;
    assign mem_wr    = active && sel && data_wr;
    assign mem_size  = !active ? 2'd0 : (sel ? data_size : 2'd2);
    assign mem_addr  = !active ? 32'd0 : (sel ? data_addr : inst_addr);
    assign mem_wstrb = (active && sel) ? data_wstrb : 4'd0;
    assign mem_wdata = (active && sel) ? data_wdata : 32'd0;

    assign inst_addr_ok = push && !sel;
    assign data_addr_ok = push && sel;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
endmodule
